// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {FILL, RUN, STALL, HALT} state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP    = 32'd4;
endpackage

// File: rtl/fetch_hold_buffer.sv
// Captures the memory word when decode stalls; the memory has no read enable,
// so its output moves on while the stalled instruction must stay visible.
module fetch_hold_buffer
  import fetch_pkg::*;
(
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        capture,
  input  logic        clear,
  input  logic        valid,
  input  logic [31:0] mem_data,
  output logic [31:0] instr,
  output logic        hold_valid
);
  logic [31:0] hold_reg;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      hold_reg   <= NOP_INSTR;
      hold_valid <= 1'b0;
    end else if (clear) begin
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_reg   <= mem_data;
      hold_valid <= 1'b1;
    end
  end

  assign instr = !valid ? NOP_INSTR : (hold_valid ? hold_reg : mem_data);
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: next-PC, IF/ID registers and stall hold buffer.
// Optional halt detection on 32'hFFFFFFFF is enabled by IF_HALT_DETECT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [31:0]       PCResult,
  output logic [31:0]       PC_In,
  output logic              PCWrite,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic [31:0]       IMemData,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [31:0]       RedirectTarget,
  output logic [31:0]       IFID_Instr,
  output logic [31:0]       IFID_PCPlus4,
  output logic              IFID_Valid,
  output logic              Halted
);
  state_e      state, state_nxt;
  logic        valid_nxt, pc4_load, capture, clear, halt_hit;
  logic [31:0] pc_plus4;

  assign pc_plus4 = PCResult + PC_STEP;
  assign PC_In    = Redirect ? RedirectTarget : pc_plus4;
  assign IMemAddr = PCResult[ADDR_W+1:2];

  always_comb begin
    state_nxt = state;
    valid_nxt = IFID_Valid;
    pc4_load  = 1'b0;
    capture   = 1'b0;
    clear     = 1'b0;
    PCWrite   = 1'b0;
    halt_hit  = 1'b0;
`ifdef IF_HALT_DETECT_EN
    halt_hit  = IFID_Valid && (IFID_Instr == HALT_INSTR) && !Redirect;
`endif
    case (state)
      HALT: valid_nxt = 1'b0;
      default: begin
        PCWrite = Redirect || !Stall;
        if (Redirect) begin
          // squash the word fetched behind the branch
          state_nxt = RUN;
          valid_nxt = 1'b0;
          clear     = 1'b1;
        end else if (halt_hit) begin
          state_nxt = HALT;
          valid_nxt = 1'b0;
        end else if (state == FILL) begin
          state_nxt = RUN;
          valid_nxt = 1'b1;
          pc4_load  = 1'b1;
        end else if (Stall) begin
          // capture only on entry; later stall cycles keep the first word
          capture   = (state == RUN);
          state_nxt = STALL;
        end else begin
          state_nxt = RUN;
          valid_nxt = 1'b1;
          pc4_load  = 1'b1;
          clear     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= FILL;
      IFID_Valid   <= 1'b0;
      IFID_PCPlus4 <= 32'h0;
    end else begin
      state      <= state_nxt;
      IFID_Valid <= valid_nxt;
      if (pc4_load) IFID_PCPlus4 <= pc_plus4;
    end
  end

`ifdef IF_HALT_DETECT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) Halted <= 1'b0;
    else        Halted <= (state_nxt == HALT);
  end
`else
  assign Halted = 1'b0;
`endif

  fetch_hold_buffer u_hold (
    .gclk       (Clock),
    .grst_n     (Reset),
    .capture    (capture),
    .clear      (clear),
    .valid      (IFID_Valid),
    .mem_data   (IMemData),
    .instr      (IFID_Instr),
    .hold_valid ()
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a PC register and synchronous memory model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCResult, PC_In, IMemData, RedirectTarget, IFID_Instr, IFID_PCPlus4;
  logic        PCWrite, Stall, Redirect, IFID_Valid, Halted;
  logic [7:0]  IMemAddr;

  logic [31:0] pc_reg, pc_force;
  logic        force_en;
  logic [31:0] mem [256];
  int          total = 0, passed = 0;

  always #5 clk = ~clk;

  assign PCResult = force_en ? pc_force : pc_reg;

  always @(posedge clk or negedge rst_n)
    if (!rst_n)       pc_reg <= 32'h0;
    else if (PCWrite) pc_reg <= PC_In;

  always @(posedge clk) IMemData <= mem[IMemAddr];

  fetch_stage #(.ADDR_W(8)) dut (
    .Clock(clk), .Reset(rst_n), .PCResult(PCResult), .PC_In(PC_In),
    .PCWrite(PCWrite), .IMemAddr(IMemAddr), .IMemData(IMemData),
    .Stall(Stall), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
    .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .Halted(Halted)
  );

  typedef struct {
    logic        stall, redir;
    logic [31:0] tgt;
    logic        pcw;
    logic [31:0] pcin;
    logic        vld;
    logic [31:0] instr, pc4;
  } vec_t;

  vec_t v [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] t);
    Stall = s; Redirect = r; RedirectTarget = t;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0);
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    force_en = 0; pc_force = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    drive(0, 0, 0);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    chk("rst_valid", {31'h0, IFID_Valid}, 32'h0);
    chk("rst_pc4",   IFID_PCPlus4, 32'h0);
    chk("rst_instr", IFID_Instr,   32'h0);
    chk("rst_halted", {31'h0, Halted}, 32'h0);
    next_cycle();
    rst_n = 1'b1;

    //          stall redir tgt     pcw pcin    vld instr        pc4
    v[0]  = '{0, 0, 32'h0,  1, 32'h04, 0, 32'h0,    32'h00};
    v[1]  = '{0, 0, 32'h0,  1, 32'h08, 1, 32'h1000, 32'h04};
    v[2]  = '{0, 0, 32'h0,  1, 32'h0C, 1, 32'h1001, 32'h08};
    v[3]  = '{1, 0, 32'h0,  0, 32'h10, 1, 32'h1002, 32'h0C};
    v[4]  = '{1, 0, 32'h0,  0, 32'h10, 1, 32'h1002, 32'h0C};
    v[5]  = '{1, 0, 32'h0,  0, 32'h10, 1, 32'h1002, 32'h0C};
    v[6]  = '{0, 0, 32'h0,  1, 32'h10, 1, 32'h1002, 32'h0C};
    v[7]  = '{0, 0, 32'h0,  1, 32'h14, 1, 32'h1003, 32'h10};
    v[8]  = '{0, 1, 32'h40, 1, 32'h40, 1, 32'h1004, 32'h14};
    v[9]  = '{0, 0, 32'h0,  1, 32'h44, 0, 32'h0,    32'h14};
    v[10] = '{0, 0, 32'h0,  1, 32'h48, 1, 32'h1010, 32'h44};
    v[11] = '{1, 0, 32'h0,  0, 32'h4C, 1, 32'h1011, 32'h48};
    v[12] = '{1, 1, 32'h80, 1, 32'h80, 1, 32'h1011, 32'h48};
    v[13] = '{0, 0, 32'h0,  1, 32'h84, 0, 32'h0,    32'h48};
    v[14] = '{0, 0, 32'h0,  1, 32'h88, 1, 32'h1020, 32'h84};
    v[15] = '{0, 0, 32'h0,  1, 32'h8C, 1, 32'h1021, 32'h88};

    for (int i = 0; i < 16; i++) begin
      drive(v[i].stall, v[i].redir, v[i].tgt);
      @(negedge clk);
      chk($sformatf("c%0d_pcwrite", i), {31'h0, PCWrite},    {31'h0, v[i].pcw});
      chk($sformatf("c%0d_pc_in", i),   PC_In,               v[i].pcin);
      chk($sformatf("c%0d_valid", i),   {31'h0, IFID_Valid}, {31'h0, v[i].vld});
      chk($sformatf("c%0d_instr", i),   IFID_Instr,          v[i].instr);
      chk($sformatf("c%0d_pc4", i),     IFID_PCPlus4,        v[i].pc4);
      next_cycle();
    end

    // PC wrap modulo 2^32 and word addressing of the top word
    drive(0, 0, 0);
    force_en = 1; pc_force = 32'hFFFF_FFFC;
    #1;
    chk("wrap_pc_in", PC_In, 32'h0);
    chk("wrap_addr", {24'h0, IMemAddr}, 32'hFF);
    force_en = 0;
    #1;

    // async reset during a stall wipes IF/ID and the hold buffer
    next_cycle();
    drive(1, 0, 0);
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, IFID_Valid}, 32'h0);
    chk("midrst_pc4",   IFID_PCPlus4, 32'h0);
    chk("midrst_instr", IFID_Instr,   32'h0);

    // halt word at index 3
    mem[3] = 32'hFFFF_FFFF;
    do_reset();
    repeat (4) next_cycle();
    @(negedge clk);
    chk("halt_word_instr", IFID_Instr, 32'hFFFF_FFFF);
    chk("halt_word_pc4", IFID_PCPlus4, 32'h10);
    chk("halt_word_halted", {31'h0, Halted}, 32'h0);
    next_cycle();
`ifdef IF_HALT_DETECT_EN
    for (int k = 0; k < 4; k++) begin
      drive(0, (k == 1), 32'h40);
      @(negedge clk);
      chk($sformatf("halt%0d_halted", k),  {31'h0, Halted},     32'h1);
      chk($sformatf("halt%0d_pcwrite", k), {31'h0, PCWrite},    32'h0);
      chk($sformatf("halt%0d_valid", k),   {31'h0, IFID_Valid}, 32'h0);
      chk($sformatf("halt%0d_instr", k),   IFID_Instr,          32'h0);
      next_cycle();
    end
    do_reset();
    @(negedge clk);
    chk("halt_cleared", {31'h0, Halted}, 32'h0);
`else
    @(negedge clk);
    chk("nohalt_halted", {31'h0, Halted}, 32'h0);
    chk("nohalt_valid",  {31'h0, IFID_Valid}, 32'h1);
    chk("nohalt_instr",  IFID_Instr, 32'h1004);
    chk("nohalt_pc4",    IFID_PCPlus4, 32'h14);
    chk("nohalt_pcwrite", {31'h0, PCWrite}, 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
